led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Shares the board's single 8-LED bank between four independent pattern sources (mode FSMs, animation engines, diagnostics) using round-robin arbitration with minimum/maximum hold times and a blanking gap between owners. It sits between the per-mode controllers and the `leds` pins. It replaces ad-hoc muxing, so that no source can monopolise or glitch the display.

## Interface
Parameters:
- `MIN_HOLD`, 13000000 — minimum cycles a grant is held (0.1 s at 130 MHz); must be ≥1.
- `MAX_HOLD`, 650000000 — cycles after which a contended owner is preempted (5 s); must be > `MIN_HOLD`.
- `GAP_CYCLES`, 1300000 — blank cycles between owners; must be ≥1.
- `IDLE_PATTERN`, 8'b00001111 — LED value when no owner.

Ports:
- `clk` in 1 — system clock, 130 MHz.
- `reset` in 1 — asynchronous, active-low reset.
- `req` in 4 — request per source, level.
- `pat0`..`pat3` in 8 each — LED pattern offered by each source.
- `leds` out 8 — registered LED drive.
- `grant` out 4 — registered one-hot grant, all-zero when none.
- `owner` out 2 — index of current/last owner.
- `busy` out 1 — high in GRANT state.
- `timeout` out 1 — one-cycle pulse on preemption.
- `state_out` out 2 — IDLE=0, GRANT=1, GAP=2.

## Operation
- All outputs registered. On reset assertion (async): state IDLE, `grant`=0, `owner`=0, `leds`=`IDLE_PATTERN`, `busy`=0, `timeout`=0, round-robin pointer `rr`=0, counters 0.
- Selection: the first index i with `req[i]`=1, searching `rr`, `rr`+1, … modulo 4.
- IDLE: `leds`=`IDLE_PATTERN`.
  - If any `req` is high, go to GRANT with the selected i: `grant`=1<<i, `owner`=i, `hold_cnt`=0.
- GRANT: each cycle `leds` <= `pat[owner]`. `hold_cnt` increments, saturating at 32 bits.
  - Normal release: `req[owner]`=0 and `hold_cnt` ≥ `MIN_HOLD`−1.
  - Preempt: `hold_cnt` ≥ `MAX_HOLD`−1 and any other `req` high. Pulse `timeout` only when the normal release condition is not also true.
  - On either release: `grant`=0, `rr` <= `owner`+1 mod 4, go to GAP, `gap_cnt`=0.
  - If `req[owner]` drops early, the grant is held until `MIN_HOLD` is satisfied and `leds` keep tracking `pat[owner]`.
  - If uncontended past `MAX_HOLD`, the owner keeps the grant indefinitely with no timeout.
- GAP: `leds`=0, `grant`=0.
  - On the `GAP_CYCLES`-th cycle: if any `req` is high, go directly to GRANT with a fresh selection (uses the updated `rr`); otherwise go to IDLE.
- The previous owner is eligible again only after the other requesters under round-robin. A previous owner re-requesting during GAP loses to any other requester.
- Pattern inputs of non-owners are ignored. `req` changes during GAP take effect only at the gap end.

## Timing
- `req` sampled at edge k in IDLE → `grant`/`busy`/`owner` valid after edge k, and `leds`=`pat` of the owner after edge k+1. The first GRANT cycle shows `IDLE_PATTERN`.
- `grant` high for at least `MIN_HOLD` cycles, and exactly `MAX_HOLD` cycles when contended throughout.
- Blank (`leds`=0, `grant`=0) for exactly `GAP_CYCLES` cycles between consecutive owners.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). The first grant after reset release favours index 0.

## Test plan
Bench parameters: `MIN_HOLD`=4, `MAX_HOLD`=16, `GAP_CYCLES`=2, `IDLE_PATTERN`=8'h0F, `patN`=8'h11·(N+1).
- Reset only, no `req` → `leds`=0x0F, `grant`=0, `busy`=0, `state_out`=0 for 50 cycles.
- `req1` pulsed 1 cycle → `grant`=0010 for exactly 4 cycles, `leds`=0x22 from the 2nd grant cycle, then 2 cycles `leds`=0, then 0x0F.
- `req[3:0]`=1111 constant → `grant` sequence 0001→0010→0100→1000→0001. Each grant lasts 16 cycles with one `timeout` pulse and a 2-cycle gap between grants.
- `req0` and `req2` held, `req0` dropped and re-raised during the first gap → `grant`=0100 next, then 0001.
- `req3` alone for 40 cycles → `grant`=1000 throughout, no `timeout`. Releases 1 cycle after `req3` falls.
- `reset` driven low mid-grant → `grant`=0 and `leds`=0x0F within the same cycle. After release with all `req` high, the first grant is 0001.

Source files
------------

// File: rtl/led_bank_arbiter_if.sv
`default_nettype none
//============================================================================
// led_bank_arbiter_if : request/pattern inputs and LED/status outputs
// Rev 1.0
//============================================================================
interface led_bank_arbiter_if;
    logic [3:0] req;
    logic [7:0] pat0;
    logic [7:0] pat1;
    logic [7:0] pat2;
    logic [7:0] pat3;
    logic [7:0] leds;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [1:0] state_out;

    modport master (
        output req, pat0, pat1, pat2, pat3,
        input  leds, grant, owner, busy, timeout, state_out
    );

    modport slave (
        input  req, pat0, pat1, pat2, pat3,
        output leds, grant, owner, busy, timeout, state_out
    );
endinterface
`default_nettype wire

// File: rtl/led_bank_arbiter.sv
`default_nettype none
//============================================================================
// led_bank_arbiter : round-robin owner of the shared 8-LED bank with hold/gap
// Rev 1.0
//============================================================================
module led_bank_arbiter #(
    parameter int unsigned MIN_HOLD     = 13000000,
    parameter int unsigned MAX_HOLD     = 650000000,
    parameter int unsigned GAP_CYCLES   = 1300000,
    parameter logic [7:0]  IDLE_PATTERN = 8'b00001111
) (
    input  wire logic              clk,
    input  wire logic              reset,
    led_bank_arbiter_if.slave      bus
);
    localparam logic [31:0] c_min_last = 32'(MIN_HOLD - 1);
    localparam logic [31:0] c_max_last = 32'(MAX_HOLD - 1);
    localparam logic [31:0] c_gap_last = 32'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_grant;
    logic [1:0]  r_owner;
    logic [1:0]  r_rr;
    logic [7:0]  r_leds;
    logic        r_busy;
    logic        r_timeout;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_gap_cnt;

    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_sel;
    logic        w_any_req;
    logic        w_release;
    logic        w_preempt;
    logic        w_gap_done;
    logic [7:0]  w_owner_pat;

    // Rotate requests so bit 0 is the round-robin pointer's index.
    assign w_rot      = 4'({bus.req, bus.req} >> r_rr);
    assign w_sel      = r_rr + w_off;
    assign w_any_req  = |bus.req;
    assign w_release  = !bus.req[r_owner] && (r_hold_cnt >= c_min_last);
    assign w_preempt  = (r_hold_cnt >= c_max_last) && (|(bus.req & ~r_grant));
    assign w_gap_done = (r_gap_cnt >= c_gap_last);

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    always_comb begin
        w_owner_pat = bus.pat0;
        case (r_owner)
            2'd1:    w_owner_pat = bus.pat1;
            2'd2:    w_owner_pat = bus.pat2;
            2'd3:    w_owner_pat = bus.pat3;
            default: w_owner_pat = bus.pat0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_GRANT;
            S_GRANT: if (w_release || w_preempt) w_next_state = S_GAP;
            S_GAP:   if (w_gap_done) w_next_state = w_any_req ? S_GRANT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant    <= 4'b0000;
            r_owner    <= 2'd0;
            r_rr       <= 2'd0;
            r_leds     <= IDLE_PATTERN;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= 32'd0;
            r_gap_cnt  <= 32'd0;
        end else begin
            r_timeout <= (r_state == S_GRANT) && w_preempt && !w_release;
            case (w_next_state)
                S_GRANT: begin
                    r_busy <= 1'b1;
                    if (r_state == S_GRANT) begin
                        r_leds <= w_owner_pat;
                        if (r_hold_cnt != 32'hFFFF_FFFF) r_hold_cnt <= r_hold_cnt + 32'd1;
                    end else begin
                        r_grant    <= 4'b0001 << w_sel;
                        r_owner    <= w_sel;
                        r_hold_cnt <= 32'd0;
                        // New owner's pattern appears one cycle after the grant.
                        r_leds     <= (r_state == S_IDLE) ? IDLE_PATTERN : 8'h00;
                    end
                end
                S_GAP: begin
                    r_busy  <= 1'b0;
                    r_grant <= 4'b0000;
                    r_leds  <= 8'h00;
                    if (r_state == S_GRANT) begin
                        r_rr      <= r_owner + 2'd1;
                        r_gap_cnt <= 32'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_grant <= 4'b0000;
                    r_leds  <= IDLE_PATTERN;
                end
            endcase
        end
    end

    assign bus.leds      = r_leds;
    assign bus.grant     = r_grant;
    assign bus.owner     = r_owner;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;
    assign bus.state_out = r_state;
endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
//============================================================================
// tb_led_bank_arbiter : scoreboard bench, expected grant episodes queued
// Rev 1.0
//============================================================================
module tb_led_bank_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_bank_arbiter_if bus_if();

    led_bank_arbiter #(
        .MIN_HOLD    (4),
        .MAX_HOLD    (16),
        .GAP_CYCLES  (2),
        .IDLE_PATTERN(8'h0F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    typedef struct {
        logic [3:0] grant;
        int         len;
        int         tmo;
        int         gap;   // blank cycles before the episode, -1 when coming from idle
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] pat_of(input int i);
        return 8'(17 * (i + 1));
    endfunction

    task automatic push(input logic [3:0] g, input int len, input int tmo, input int gap);
        exp_t e;
        e.grant = g; e.len = len; e.tmo = tmo; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic reset_now();
        reset = 1'b0;
        #1;
        check("rst_grant",   32'(bus_if.grant),     32'h0);
        check("rst_leds",    32'(bus_if.leds),      32'h0F);
        check("rst_busy",    32'(bus_if.busy),      32'h0);
        check("rst_state",   32'(bus_if.state_out), 32'h0);
        check("rst_owner",   32'(bus_if.owner),     32'h0);
        check("rst_timeout", 32'(bus_if.timeout),   32'h0);
    endtask

    // Monitor: models idle/gap/grant phases and scores each finished grant episode.
    initial begin
        int         zcount;
        bit         in_ep;
        logic [3:0] ep_grant;
        int         ep_len, ep_tmo, ep_gap;
        exp_t       e;
        zcount = 100; in_ep = 0; ep_grant = 4'b0; ep_len = 0; ep_tmo = 0; ep_gap = -1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                in_ep  = 0;
                zcount = 100;
            end else if (bus_if.grant != 4'b0000) begin
                if (!in_ep) begin
                    in_ep    = 1;
                    ep_grant = bus_if.grant;
                    ep_len   = 0;
                    ep_tmo   = 0;
                    ep_gap   = (zcount <= 2) ? zcount : -1;
                end
                ep_len++;
                ep_tmo += int'(bus_if.timeout);
                check("grant_stable", 32'(bus_if.grant), 32'(ep_grant));
                check("owner",        32'(bus_if.owner), 32'(idx_of(ep_grant)));
                check("busy_grant",   32'(bus_if.busy),  32'h1);
                check("state_grant",  32'(bus_if.state_out), 32'h1);
                if (ep_len >= 2)
                    check("leds_owner", 32'(bus_if.leds), 32'(pat_of(idx_of(ep_grant))));
                else if (ep_gap < 0)
                    check("leds_first_from_idle", 32'(bus_if.leds), 32'h0F);
                zcount = 0;
            end else begin
                zcount++;
                if (in_ep) begin
                    in_ep = 0;
                    ep_tmo += int'(bus_if.timeout);
                    check("sb_has_entry", 32'(sb.size() != 0), 32'h1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("ep_grant",   32'(ep_grant), 32'(e.grant));
                        check("ep_len",     32'(ep_len),   32'(e.len));
                        check("ep_timeout", 32'(ep_tmo),   32'(e.tmo));
                        check("ep_gap",     32'(ep_gap),   32'(e.gap));
                    end
                end else begin
                    check("timeout_idle", 32'(bus_if.timeout), 32'h0);
                end
                check("busy_off", 32'(bus_if.busy), 32'h0);
                if (zcount <= 2) begin
                    check("leds_gap",  32'(bus_if.leds),      32'h00);
                    check("state_gap", 32'(bus_if.state_out), 32'h2);
                end else begin
                    check("leds_idle",  32'(bus_if.leds),      32'h0F);
                    check("state_idle", 32'(bus_if.state_out), 32'h0);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus_if.req  = 4'b0000;
        bus_if.pat0 = 8'h11;
        bus_if.pat1 = 8'h22;
        bus_if.pat2 = 8'h33;
        bus_if.pat3 = 8'h44;
        #2;
        reset_now();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle only: monitor checks idle outputs every cycle.
        repeat (50) @(negedge clk);

        // Single-cycle req1 pulse: held for MIN_HOLD.
        push(4'b0010, 4, 0, -1);
        bus_if.req = 4'b0010;
        @(negedge clk);
        bus_if.req = 4'b0000;
        repeat (12) @(negedge clk);

        // All requesting: full rotation with preemption, then drop mid fifth grant.
        reset_now();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(4'b0001, 16, 1, -1);
        push(4'b0010, 16, 1, 2);
        push(4'b0100, 16, 1, 2);
        push(4'b1000, 16, 1, 2);
        push(4'b0001, 6, 0, 2);
        bus_if.req = 4'b1111;
        repeat (78) @(negedge clk);
        bus_if.req = 4'b0000;
        repeat (10) @(negedge clk);

        // req0/req2 contend; req0 bounces during the gap and still loses.
        reset_now();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(4'b0001, 16, 1, -1);
        push(4'b0100, 16, 1, 2);
        push(4'b0001, 4, 0, 2);
        bus_if.req = 4'b0101;
        repeat (17) @(negedge clk);
        bus_if.req = 4'b0100;
        @(negedge clk);
        bus_if.req = 4'b0101;
        repeat (22) @(negedge clk);
        bus_if.req = 4'b0000;
        repeat (10) @(negedge clk);

        // Uncontended owner past MAX_HOLD: no preemption.
        push(4'b1000, 40, 0, -1);
        bus_if.req = 4'b1000;
        repeat (40) @(negedge clk);
        bus_if.req = 4'b0000;
        repeat (10) @(negedge clk);

        // Reset mid-grant, then all requesting: index 0 wins first.
        bus_if.req = 4'b0010;
        repeat (3) @(negedge clk);
        reset_now();
        bus_if.req = 4'b1111;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(4'b0001, 5, 0, -1);
        repeat (5) @(negedge clk);
        bus_if.req = 4'b0000;
        repeat (10) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
